inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Parametrised instruction-memory front end for stack_cpu: owns instruction RAM, a boot-load phase and a fetch FSM.
//  Load phase: an external loader writes the program word by word.
//  Run phase: serves one instruction per CPU completion, with a registered handshake.
//  Sits between the system-level loader/testbench and stack_cpu; replaces ad-hoc task-based fetching.
// PARAMETERS
//  DATA_W   32   instruction/PC width
//  DEPTH    64   instruction words; power of two, >=2
//  ADDR_W   $clog2(DEPTH)   RAM index width (derived, localparam)
// PORTS
//  clk                 in   1       system clock, all logic on posedge
//  rst_n               in   1       synchronous active-low reset
//  load_valid          in   1       write load_data to load_addr (LOAD state only)
//  load_addr           in   ADDR_W  load word index
//  load_data           in   DATA_W  load word
//  load_done           in   1       end of load phase
//  load_ready          out  1       high while in LOAD
//  prog_len            out  ADDR_W+1  highest loaded index +1
//  cpu_inst_complete   in   1       CPU finished current instruction; fetch at cpu_pc_next
//  cpu_pc_next         in   DATA_W  next PC (word index)
//  cpu_inst            out  DATA_W  fetched instruction, held until next fetch
//  cpu_inst_ready      out  1       one-cycle pulse: cpu_inst valid
//  busy                out  1       fetch in flight (RD or RESP)
//  fetch_count         out  16      fetches served since reset, saturating at 16'hFFFF
//  fetch_fault         out  1       sticky; bounds fault (only with FETCH_BOUNDS_CHECK_EN, else tied 0)
// BEHAVIOUR
//  Reset (rst_n==0 at posedge):
//   - state=LOAD; outputs zero except load_ready=1: cpu_inst, cpu_inst_ready, busy, prog_len, fetch_count, fetch_fault=0.
//   - RAM contents are NOT cleared; reset mid-fetch aborts with no inst_ready pulse.
//  RAM: DEPTH x DATA_W, synchronous write, synchronous read (data one cycle after address).
//  FSM states:
//   - LOAD
//     - load_valid: RAM[load_addr]<=load_data; prog_len<=max(prog_len, load_addr+1).
//     - load_done: ->IDLE. load_valid and load_done in the same cycle: write happens, then ->IDLE.
//   - IDLE
//     - cpu_inst_complete: capture cpu_pc_next, issue read ->RD; else stay.
//     - load_* ignored outside LOAD.
//   - RD: RAM output settles ->RESP.
//   - RESP: cpu_inst<=RAM dout; cpu_inst_ready=1 for exactly this cycle; fetch_count++ (saturating) ->IDLE.
//  Latency:
//   - complete sampled at edge N -> cpu_inst_ready high during cycle N+2.
//   - Back-to-back fetch possible when complete is sampled at edge N+3 (IDLE).
//  cpu_inst_complete in RD/RESP: ignored (no queueing); CPU must re-assert after inst_ready.
//  PC mapping without macro: index = cpu_pc_next[ADDR_W-1:0] (wraps modulo DEPTH).
//  Reads of never-loaded words return RAM contents as-is (X in sim); not flagged.
//  busy = (state==RD)||(state==RESP).
// CONFIGURATION
//  FETCH_BOUNDS_CHECK_EN defined:
//   - complete in IDLE with cpu_pc_next >= prog_len: no read; fetch_fault<=1 (sticky until reset).
//   - Next cycle: cpu_inst<=32'h0 (stack_cpu NOP) with cpu_inst_ready pulse; state stays IDLE.
//   - fetch_count does not increment on faulted fetches.
//  FETCH_BOUNDS_CHECK_EN undefined: no comparison logic; fetch_fault tied 0; wrap rule applies.
// TESTING
//  - Reset, then load 0..3 = {134217754,805306368,134217729,1342177280} + load_done
//    -> prog_len=4, load_ready=0 next cycle.
//  - After load, complete with pc_next=2 at edge N -> cpu_inst=134217729, inst_ready pulse at N+2 only; busy in N+1..N+2.
//  - Four back-to-back fetches pc 0..3 -> fetch_count=4; complete held during RD/RESP causes no extra fetch.
//  - Load with load_valid+load_done same cycle at addr 5, data 7
//    -> RAM[5]=7, prog_len=6; later load_valid in IDLE does not change RAM.
//  - Without macro, DEPTH=64, pc_next=66 -> returns RAM[2].
//    With FETCH_BOUNDS_CHECK_EN, pc_next=66 -> fetch_fault=1, cpu_inst=0, count unchanged.
//  - rst_n low during RD -> no inst_ready; LOAD state, load_ready=1; RAM[2] still reads 134217729 after reload-done.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction RAM with boot-load phase and fetch FSM for stack_cpu.
// Optional bounds checking of fetch PCs is enabled by defining FETCH_BOUNDS_CHECK_EN.
module inst_fetch_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 64,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_done,
   output logic              load_ready,
   output logic [ADDR_W:0]   prog_len,
   input  logic              cpu_inst_complete,
   input  logic [DATA_W-1:0] cpu_pc_next,
   output logic [DATA_W-1:0] cpu_inst,
   output logic              cpu_inst_ready,
   output logic              busy,
   output logic [15:0]       fetch_count,
   output logic              fetch_fault
);

   typedef enum logic [1:0] {StLoad, StIdle, StRd, StResp} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   cpu_inst_q, cpu_inst_d;
   logic                inst_ready_q, inst_ready_d;
   logic [ADDR_W:0]     prog_len_q, prog_len_d;
   logic [15:0]         fetch_count_q, fetch_count_d;
   logic [DATA_W-1:0]   ram [DEPTH];
   logic [DATA_W-1:0]   ram_dout_q;
   logic                ram_we, ram_re;
   logic [ADDR_W:0]     load_end;

`ifdef FETCH_BOUNDS_CHECK_EN
   logic                fault_q, fault_d;
   logic                pc_oob;

   assign pc_oob      = cpu_pc_next >= DATA_W'(prog_len_q);
   assign fetch_fault = fault_q;
`else
   logic                unused_pc_hi;

   assign unused_pc_hi = ^cpu_pc_next[DATA_W-1:ADDR_W];
   assign fetch_fault  = 1'b0;
`endif

   assign load_end = {1'b0, load_addr} + 1'b1;

   always_comb begin
      state_d       = state_q;
      cpu_inst_d    = cpu_inst_q;
      inst_ready_d  = 1'b0;
      prog_len_d    = prog_len_q;
      fetch_count_d = fetch_count_q;
      ram_we        = 1'b0;
      ram_re        = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_d       = fault_q;
`endif
      unique case (state_q)
         StLoad: begin
            if (load_valid) begin
               ram_we = 1'b1;
               if (load_end > prog_len_q) prog_len_d = load_end;
            end
            if (load_done) state_d = StIdle;
         end
         StIdle: begin
            if (cpu_inst_complete) begin
`ifdef FETCH_BOUNDS_CHECK_EN
               if (pc_oob) begin
                  // Out-of-range fetch answers with a NOP instead of touching RAM.
                  fault_d      = 1'b1;
                  cpu_inst_d   = '0;
                  inst_ready_d = 1'b1;
               end else begin
                  ram_re  = 1'b1;
                  state_d = StRd;
               end
`else
               ram_re  = 1'b1;
               state_d = StRd;
`endif
            end
         end
         StRd: begin
            // Register the RAM word now so it is visible alongside the ready pulse in RESP.
            state_d      = StResp;
            cpu_inst_d   = ram_dout_q;
            inst_ready_d = 1'b1;
            if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StLoad;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StLoad;
         cpu_inst_q    <= '0;
         inst_ready_q  <= 1'b0;
         prog_len_q    <= '0;
         fetch_count_q <= '0;
`ifdef FETCH_BOUNDS_CHECK_EN
         fault_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cpu_inst_q    <= cpu_inst_d;
         inst_ready_q  <= inst_ready_d;
         prog_len_q    <= prog_len_d;
         fetch_count_q <= fetch_count_d;
`ifdef FETCH_BOUNDS_CHECK_EN
         fault_q       <= fault_d;
`endif
      end
   end

   // Contents survive reset; only writes are suppressed while reset is asserted.
   always_ff @(posedge clk) begin
      if (ram_we && rst_n) ram[load_addr] <= load_data;
      if (ram_re) ram_dout_q <= ram[cpu_pc_next[ADDR_W-1:0]];
   end

   assign load_ready     = (state_q == StLoad);
   assign busy           = (state_q == StRd) || (state_q == StResp);
   assign prog_len       = prog_len_q;
   assign cpu_inst       = cpu_inst_q;
   assign cpu_inst_ready = inst_ready_q;
   assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed table-driven bench for inst_fetch_unit, plus hand-written fetch/reset sequences.
module tb_inst_fetch_unit;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 6;
   localparam logic [31:0] W0 = 32'd134217754;
   localparam logic [31:0] W1 = 32'd805306368;
   localparam logic [31:0] W2 = 32'd134217729;
   localparam logic [31:0] W3 = 32'd1342177280;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load_valid = 1'b0;
   logic [ADDR_W-1:0] load_addr = '0;
   logic [DATA_W-1:0] load_data = '0;
   logic              load_done = 1'b0;
   logic              load_ready;
   logic [ADDR_W:0]   prog_len;
   logic              cpu_inst_complete = 1'b0;
   logic [DATA_W-1:0] cpu_pc_next = '0;
   logic [DATA_W-1:0] cpu_inst;
   logic              cpu_inst_ready;
   logic              busy;
   logic [15:0]       fetch_count;
   logic              fetch_fault;

   int n_chk = 0;
   int n_fail = 0;

   inst_fetch_unit #(.DATA_W(32), .DEPTH(64)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .load_valid        (load_valid),
      .load_addr         (load_addr),
      .load_data         (load_data),
      .load_done         (load_done),
      .load_ready        (load_ready),
      .prog_len          (prog_len),
      .cpu_inst_complete (cpu_inst_complete),
      .cpu_pc_next       (cpu_pc_next),
      .cpu_inst          (cpu_inst),
      .cpu_inst_ready    (cpu_inst_ready),
      .busy              (busy),
      .fetch_count       (fetch_count),
      .fetch_fault       (fetch_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        lv;
      logic [5:0]  la;
      logic [31:0] ld;
      logic        dn;
      logic        cmp;
      logic [31:0] pc;
      logic        e_lr;
      logic [6:0]  e_pl;
      logic        e_rdy;
      logic        e_busy;
      logic [31:0] e_inst;
      logic [15:0] e_cnt;
      logic        e_flt;
   } vec_t;

   vec_t vecs[$];

   task automatic row(input logic rst, input logic lv, input logic [5:0] la, input logic [31:0] ld,
                      input logic dn, input logic cmp, input logic [31:0] pc, input logic e_lr,
                      input logic [6:0] e_pl, input logic e_rdy, input logic e_busy,
                      input logic [31:0] e_inst, input logic [15:0] e_cnt, input logic e_flt);
      vec_t v;
      v = '{rst, lv, la, ld, dn, cmp, pc, e_lr, e_pl, e_rdy, e_busy, e_inst, e_cnt, e_flt};
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic idle_inputs();
      load_valid        = 1'b0;
      load_addr         = '0;
      load_data         = '0;
      load_done         = 1'b0;
      cpu_inst_complete = 1'b0;
      cpu_pc_next       = '0;
   endtask

   // One fetch through the handshake; ready must rise one edge after the RD entry edge.
   task automatic fetch(input logic [31:0] pc, input logic hold, input logic [31:0] exp_inst,
                        input int idx);
      int lat;
      @(negedge clk);
      cpu_inst_complete = 1'b1;
      cpu_pc_next       = pc;
      @(posedge clk); #1;
      chk("fetch_busy_rd", idx, 32'(busy), 32'd1);
      chk("fetch_rdy_rd", idx, 32'(cpu_inst_ready), 32'd0);
      @(negedge clk);
      if (!hold) cpu_inst_complete = 1'b0;
      lat = 0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         if (cpu_inst_ready) begin
            lat = i;
            break;
         end
      end
      chk("fetch_latency", idx, 32'(lat), 32'd1);
      chk("fetch_inst", idx, cpu_inst, exp_inst);
      @(negedge clk);
      cpu_inst_complete = 1'b0;
      @(posedge clk); #1;
      chk("fetch_rdy_after", idx, 32'(cpu_inst_ready), 32'd0);
      chk("fetch_busy_after", idx, 32'(busy), 32'd0);
      chk("fetch_inst_hold", idx, cpu_inst, exp_inst);
   endtask

   initial begin
      //   rst lv la  ld     dn cmp pc     | lr pl rdy busy inst  cnt flt
      row(0, 0, 0, 0,     0, 0, 0,      1, 0, 0, 0, 0,  0, 0);
      row(1, 1, 0, W0,    0, 0, 0,      1, 1, 0, 0, 0,  0, 0);
      row(1, 1, 1, W1,    0, 0, 0,      1, 2, 0, 0, 0,  0, 0);
      row(1, 1, 3, W3,    0, 0, 0,      1, 4, 0, 0, 0,  0, 0);
      row(1, 1, 2, W2,    0, 0, 0,      1, 4, 0, 0, 0,  0, 0);
      row(1, 0, 0, 0,     1, 0, 0,      0, 4, 0, 0, 0,  0, 0);
      row(1, 0, 0, 0,     0, 1, 2,      0, 4, 0, 1, 0,  0, 0);
      row(1, 0, 0, 0,     0, 1, 0,      0, 4, 1, 1, W2, 1, 0);
      row(1, 0, 0, 0,     0, 1, 0,      0, 4, 0, 0, W2, 1, 0);
      row(1, 0, 0, 0,     0, 1, 0,      0, 4, 0, 1, W2, 1, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 1, 1, W0, 2, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 0, 0, W0, 2, 0);
      row(1, 0, 0, 0,     0, 1, 1,      0, 4, 0, 1, W0, 2, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 1, 1, W1, 3, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 0, 0, W1, 3, 0);
      row(1, 0, 0, 0,     0, 1, 3,      0, 4, 0, 1, W1, 3, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 1, 1, W3, 4, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 0, 0, W3, 4, 0);
      row(1, 1, 2, 99,    0, 0, 0,      0, 4, 0, 0, W3, 4, 0);
      row(1, 0, 0, 0,     0, 1, 2,      0, 4, 0, 1, W3, 4, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 1, 1, W2, 5, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 0, 0, W2, 5, 0);
`ifdef FETCH_BOUNDS_CHECK_EN
      row(1, 0, 0, 0,     0, 1, 66,     0, 4, 1, 0, 0,  5, 1);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 0, 0, 0,  5, 1);
      row(1, 0, 0, 0,     0, 1, 4,      0, 4, 1, 0, 0,  5, 1);
      row(1, 0, 0, 0,     0, 1, 3,      0, 4, 0, 1, 0,  5, 1);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 1, 1, W3, 6, 1);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 0, 0, W3, 6, 1);
`else
      row(1, 0, 0, 0,     0, 1, 66,     0, 4, 0, 1, W2, 5, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 1, 1, W2, 6, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 0, 0, W2, 6, 0);
      row(1, 0, 0, 0,     0, 1, 67,     0, 4, 0, 1, W2, 6, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 1, 1, W3, 7, 0);
      row(1, 0, 0, 0,     0, 0, 0,      0, 4, 0, 0, W3, 7, 0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst_n             = vecs[i].rst;
         load_valid        = vecs[i].lv;
         load_addr         = vecs[i].la;
         load_data         = vecs[i].ld;
         load_done         = vecs[i].dn;
         cpu_inst_complete = vecs[i].cmp;
         cpu_pc_next       = vecs[i].pc;
         @(posedge clk); #1;
         chk("load_ready", i, 32'(load_ready), 32'(vecs[i].e_lr));
         chk("prog_len", i, 32'(prog_len), 32'(vecs[i].e_pl));
         chk("inst_ready", i, 32'(cpu_inst_ready), 32'(vecs[i].e_rdy));
         chk("busy", i, 32'(busy), 32'(vecs[i].e_busy));
         chk("cpu_inst", i, cpu_inst, vecs[i].e_inst);
         chk("fetch_count", i, 32'(fetch_count), 32'(vecs[i].e_cnt));
         chk("fetch_fault", i, 32'(fetch_fault), 32'(vecs[i].e_flt));
      end
      @(negedge clk);
      idle_inputs();

      // Held complete through RD/RESP must not start a second fetch.
      fetch(32'd0, 1'b1, W0, 100);
`ifdef FETCH_BOUNDS_CHECK_EN
      chk("count_after_held", 100, 32'(fetch_count), 32'd7);
`else
      chk("count_after_held", 100, 32'(fetch_count), 32'd8);
`endif

      // Reset while in RD: no ready pulse, back in LOAD, RAM preserved.
      @(negedge clk);
      cpu_inst_complete = 1'b1;
      cpu_pc_next       = 32'd2;
      @(posedge clk); #1;
      chk("rst_mid_busy", 200, 32'(busy), 32'd1);
      @(negedge clk);
      cpu_inst_complete = 1'b0;
      rst_n             = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_rdy", 200, 32'(cpu_inst_ready), 32'd0);
      chk("rst_mid_lr", 200, 32'(load_ready), 32'd1);
      chk("rst_mid_busy0", 200, 32'(busy), 32'd0);
      chk("rst_mid_cnt", 200, 32'(fetch_count), 32'd0);
      chk("rst_mid_pl", 200, 32'(prog_len), 32'd0);
      chk("rst_mid_inst", 200, cpu_inst, 32'd0);
      chk("rst_mid_flt", 200, 32'(fetch_fault), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_post_rdy", 201, 32'(cpu_inst_ready), 32'd0);
      chk("rst_post_lr", 201, 32'(load_ready), 32'd1);

      // Write and done in the same cycle.
      @(negedge clk);
      load_valid = 1'b1;
      load_addr  = 6'd5;
      load_data  = 32'd7;
      load_done  = 1'b1;
      @(posedge clk); #1;
      chk("same_cyc_lr", 202, 32'(load_ready), 32'd0);
      chk("same_cyc_pl", 202, 32'(prog_len), 32'd6);
      @(negedge clk);
      idle_inputs();

      fetch(32'd2, 1'b0, W2, 203);
      fetch(32'd5, 1'b0, 32'd7, 204);

      // Load port is inert outside LOAD.
      @(negedge clk);
      load_valid = 1'b1;
      load_addr  = 6'd5;
      load_data  = 32'd55;
      @(posedge clk); #1;
      chk("idle_load_pl", 205, 32'(prog_len), 32'd6);
      @(negedge clk);
      idle_inputs();
      fetch(32'd5, 1'b0, 32'd7, 206);
      chk("final_count", 207, 32'(fetch_count), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
